mux_arb_n: RTL and testbench
============================

Name: mux_arb_n

Overview:
- Parametrised N-to-1 datapath selector with valid/ready handshaking and a registered output stage.
- Next generation of the team's fixed 2/4/5/6-to-1 combinational muxes.
- Supports explicit-select mode (drop-in for the legacy muxes) and round-robin arbitration mode.
- Sits between crypto-module producers (key schedule, round engine, bus reads) and a shared consumer such as the result register or bus write port.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 6, number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_IN), width of the select and source-index fields; derived, not overridden.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready; combinational.
- mode  in  1  0 = explicit select, 1 = round-robin.
- sel  in  SEL_W  channel index used in explicit mode.
- out_data  out  WIDTH  registered output word.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts a word.
- out_src  out  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (RST=1 at a rising CLK edge):
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer rr_ptr=NUM_IN-1, so the first search starts at channel 0.
  - Reset mid-transfer discards the held word; no in_ready is asserted that cycle.
- Load enable: load_en = !out_valid | out_ready. The output register accepts a new word in the same cycle the old one drains, so back-to-back throughput is 1 word/cycle.
- Grant, explicit mode (mode=0):
  - gnt = sel if sel < NUM_IN, else channel 0. This matches the legacy mux default.
  - Only channel gnt may transfer. Other channels' valids are ignored.
- Grant, round-robin mode (mode=1):
  - Search channels rr_ptr+1, rr_ptr+2, … modulo NUM_IN; gnt = first channel with in_valid=1.
  - No valid channel means no grant.
- in_ready[i] = load_en & (i==gnt) & grant_exists. All other in_ready bits are 0.
- Transfer occurs when in_ready[gnt] & in_valid[gnt] at the edge. Next cycle:
  - out_data = channel gnt word, out_src = gnt, out_valid = 1.
  - rr_ptr updates to gnt in round-robin mode only.
- Latency: 1 cycle from input transfer to out_valid.
- Drain without refill (out_ready=1, no transfer): out_valid returns to 0. out_data and out_src hold their last values.
- Stall (out_valid=1, out_ready=0): out_data and out_src stay stable; all in_ready are 0; rr_ptr does not change.
- Mode or sel changes take effect on the next grant decision. A word already held is unaffected.
- Wrap-around: with rr_ptr=NUM_IN-1 the search starts at channel 0. A single active channel is granted every cycle.
- No combinational path from in_valid or in_data to out_*. The only combinational outputs are in_ready, driven from out_ready, out_valid, in_valid, mode, sel and rr_ptr.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- When defined:
  - Adds input port in_lock (width NUM_IN), placed after in_valid.
  - In round-robin mode, if the channel last transferred (index rr_ptr) presents in_valid=1 with in_lock=1, it is granted again ahead of the normal search. This allows multi-word bursts such as a 128-bit key as 4×32.
  - The lock is released when that channel transfers a word with in_lock=0, or drops in_valid.
  - Explicit mode ignores in_lock.
- When undefined: no in_lock port; pure round-robin.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then all in_valid=0 → out_valid=0, out_data=0, out_src=0, in_ready=0 throughout.
- Explicit mode, NUM_IN=6:
  - mode=0, sel=3, all valid, in_data[i]=32'hA0+i, out_ready=1 → in_ready=6'b001000; next cycle out_data=32'hA3, out_src=3.
  - sel=7 → channel 0 granted; out_data=32'hA0.
- Round-robin fairness: mode=1, all 6 channels valid continuously, out_ready=1 → out_src sequence 0,1,2,3,4,5,0,… with one word per cycle and no gaps.
- Backpressure: mode=1, word from channel 2 held, out_ready=0 for 5 cycles → out_data and out_src stable, in_ready=0. On release, channel 3 is granted in the same cycle.
- Sparse and wrap: mode=1, only channels 5 and 1 valid, rr_ptr=5 → grant order 1,5,1,5. Then mid-stream RST → out_valid=0 next cycle; after reset the first grant is 1.
- Lock (MUX_ARB_LOCK_EN defined): mode=1, channel 2 sends 4 words with in_lock=1,1,1,0 while channels 0 and 4 are valid → out_src=2,2,2,2, then 4, then 0.

Source files
------------

// File: rtl/mux_arb_n.sv
// mux_arb_n -- parametrised N-to-1 selector with valid/ready handshaking
// and a registered output stage.
//
// Two grant modes:
//   mode = 0 : explicit select. The channel named by sel wins. An
//              out-of-range sel falls back to channel 0, which is how the
//              legacy fixed-width muxes behave.
//   mode = 1 : round-robin. The search starts one channel past the last
//              winner (rr_ptr) and wraps modulo NUM_IN.
//
// The output register refills in the same cycle that it drains, so a
// continuous stream moves one word per cycle. in_ready is the only
// combinational output. in_valid and in_data reach out_* only through the
// output register.
//
// Optional feature, enabled by defining MUX_ARB_LOCK_EN:
//   Adds the in_lock port. In round-robin mode, a channel that transferred
//   a word with in_lock=1 keeps the grant for as long as it holds in_valid.
//   The channel ends its burst by sending a word with in_lock=0.
//   Explicit mode ignores in_lock.

module mux_arb_n #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 6,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NUM_IN-1:0]       in_lock,
`endif
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_src;
  logic [SEL_W-1:0] r_rr_ptr;    // last channel granted in round-robin mode

  // ---------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] w_ch [NUM_IN];  // unpacked view of in_data
  logic             w_load_en;      // output register may take a new word
  logic [SEL_W-1:0] w_exp_gnt;      // explicit-mode grant
  logic [SEL_W-1:0] w_rr_gnt;       // round-robin search result
  logic             w_rr_found;     // round-robin search found a valid channel
  logic [SEL_W-1:0] w_gnt;          // grant in effect for this cycle
  logic             w_gnt_found;    // a grant exists this cycle
  logic             w_xfer;         // granted channel transfers at this edge

  // Split the packed input bus into one word per channel.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
    assign w_ch[g] = in_data[g*WIDTH +: WIDTH];
  end

  // The register can load when it is empty or when its word leaves this cycle.
  assign w_load_en = !r_out_valid || out_ready;

  // An out-of-range select falls back to channel 0, as the legacy mux does.
  assign w_exp_gnt = (int'(sel) < NUM_IN) ? sel : '0;

  // Round-robin search from rr_ptr+1 upward, modulo NUM_IN.
  always_comb begin
    int               v_idx;
    logic [SEL_W-1:0] v_ch;
    // NOTE: every signal written in an always_comb gets a default before any
    // conditional assignment. A path that skips an assignment would
    // otherwise infer a latch.
    w_rr_found = 1'b0;
    w_rr_gnt   = '0;
    v_idx      = 0;
    v_ch       = '0;
    // Walk from the farthest candidate to the nearest. The nearest valid
    // channel is written last, so it wins without an early exit.
    for (int k = NUM_IN; k >= 1; k--) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NUM_IN) begin
        v_idx = v_idx - NUM_IN;
      end
      v_ch = SEL_W'(v_idx);
      if (in_valid[v_ch]) begin
        w_rr_found = 1'b1;
        w_rr_gnt   = v_ch;
      end
    end
  end

`ifdef MUX_ARB_LOCK_EN
  logic r_lock_hold;  // previous winner asked to keep the grant
  logic w_lock_hit;   // the held lock applies this cycle

  assign w_lock_hit = r_lock_hold && in_valid[r_rr_ptr];

  // Select the grant for the active mode. A held lock pre-empts the search.
  always_comb begin
    w_gnt       = w_exp_gnt;
    w_gnt_found = 1'b1;
    if (mode) begin
      if (w_lock_hit) begin
        w_gnt       = r_rr_ptr;
        w_gnt_found = 1'b1;
      end else begin
        w_gnt       = w_rr_gnt;
        w_gnt_found = w_rr_found;
      end
    end
  end
`else
  // Select the grant for the active mode.
  always_comb begin
    w_gnt       = w_exp_gnt;
    w_gnt_found = 1'b1;
    if (mode) begin
      w_gnt       = w_rr_gnt;
      w_gnt_found = w_rr_found;
    end
  end
`endif

  // At most one in_ready bit is set: the granted channel's, and only when
  // the register can load. RST holds every bit low so the reset cycle
  // discards any word that is offered.
  always_comb begin
    in_ready = '0;
    if (w_load_en && w_gnt_found && !RST) begin
      in_ready[w_gnt] = 1'b1;
    end
  end

  assign w_xfer = |(in_ready & in_valid);

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------

  // Output register. Load the granted word, or drain to empty and keep the
  // last data and source.
  always_ff @(posedge CLK) begin
    // NOTE: clocked state uses non-blocking assignments only. Every register
    // then samples values from before the edge, whatever order the blocks
    // execute in.
    if (RST) begin
      // NOTE: out_data and out_src are reset as well as out_valid. Their
      // reset value of zero is visible at the ports, so they are not
      // don't-care data registers.
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_ch[w_gnt];
        r_out_src  <= w_gnt;
      end
    end
  end

  // Round-robin pointer. It moves only on a round-robin transfer, so a
  // stall or an explicit-mode transfer leaves the fairness order unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rr_ptr <= SEL_W'(NUM_IN - 1);
    end else if (w_xfer && mode) begin
      r_rr_ptr <= w_gnt;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  // Burst lock. Set or clear it from the in_lock bit of each round-robin
  // transfer. Also release it when the owner drops in_valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lock_hold <= 1'b0;
    end else if (w_xfer && mode) begin
      r_lock_hold <= in_lock[w_gnt];
    end else if (!in_valid[r_rr_ptr]) begin
      r_lock_hold <= 1'b0;
    end
  end
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_arb_n.sv
// Testbench for mux_arb_n (WIDTH=32, NUM_IN=6).
// A directed driver applies one vector per cycle and checks in_ready in
// that cycle. For every transfer it expects, it pushes the expected word
// and source onto a scoreboard queue. A separate monitor compares whatever
// word the DUT presents against the head of the queue and pops the entry
// when the consumer accepts it. The lock scenario is compiled only when
// MUX_ARB_LOCK_EN is defined.

module tb_mux_arb_n;

  localparam int W = 32;
  localparam int N = 6;

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   src;
  } exp_t;

  logic         CLK;
  logic         RST;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic         mode;
  logic [2:0]   sel;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_src;
`ifdef MUX_ARB_LOCK_EN
  logic [N-1:0] in_lock;
  logic [N-1:0] lock_pend;
`endif

  exp_t     sb_q[$];
  int       n_vec;
  int       n_cmp;
  int       n_err;
  bit       flush_pend;
  int       last_tag;
  logic [W-1:0] hold_word;

  mux_arb_n #(.WIDTH(W), .NUM_IN(N)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef MUX_ARB_LOCK_EN
    .in_lock   (in_lock),
`endif
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Channel i carries 0xA0+i in its low byte and the vector number above
  // it, so every word in the run is distinct.
  function automatic logic [W-1:0] word(input int tag, input int ch);
    return (W'(tag) << 8) | (W'(32'hA0) + W'(ch));
  endfunction

  task automatic check(input string name, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Apply one vector after the next rising edge and check in_ready in the
  // same cycle. When xfer is set, queue the word that should appear.
  task automatic apply(input logic rst, input logic md, input logic [2:0] s,
                       input logic [N-1:0] v, input logic ordy,
                       input logic [N-1:0] exp_rdy, input logic xfer,
                       input logic [2:0] src);
    exp_t e;
    @(posedge CLK);
    #1;
    if (flush_pend) begin
      sb_q.delete();
      flush_pend = 1'b0;
    end
    RST       = rst;
    mode      = md;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
`ifdef MUX_ARB_LOCK_EN
    in_lock   = lock_pend;
`endif
    for (int i = 0; i < N; i++) begin
      in_data[i*W +: W] = word(n_vec, i);
    end
    if (xfer) begin
      e.data = word(n_vec, int'(src));
      e.src  = src;
      sb_q.push_back(e);
    end
    if (rst) flush_pend = 1'b1;
    last_tag = n_vec;
    n_vec++;
    @(negedge CLK);
    check("in_ready", W'(in_ready), W'(exp_rdy));
  endtask

  task automatic check_idle(input logic [W-1:0] exp_data,
                            input logic [2:0] exp_src);
    check("idle_out_valid", W'(out_valid), W'(1'b0));
    check("idle_out_data", out_data, exp_data);
    check("idle_out_src", W'(out_src), W'(exp_src));
  endtask

  // Scoreboard monitor: compare each presented word with the queue head and
  // pop it once the consumer takes it.
  always @(negedge CLK) begin
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got data=%h src=%0d, expected no word",
                 out_data, out_src);
      end else begin
        check("sb_data", out_data, sb_q[0].data);
        check("sb_src", W'(out_src), W'(sb_q[0].src));
        if (out_ready === 1'b1) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    n_vec = 0; n_cmp = 0; n_err = 0; flush_pend = 1'b0; last_tag = 0;
    hold_word = '0;
    RST = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b1;
    in_data = '0;
`ifdef MUX_ARB_LOCK_EN
    in_lock = '0; lock_pend = '0;
`endif

    // Reset for two cycles, then idle in round-robin mode with no valids.
    apply(1, 1, 0, 6'h00, 1, 6'h00, 0, 0);
    apply(1, 1, 0, 6'h00, 1, 6'h00, 0, 0);
    check_idle('0, 3'd0);
    repeat (2) begin
      apply(0, 1, 0, 6'h00, 1, 6'h00, 0, 0);
      check_idle('0, 3'd0);
    end

    // Explicit mode: out-of-range sel falls back to 0, then sel=3.
    apply(0, 0, 3'd7, 6'h3F, 1, 6'b000001, 1, 3'd0);
    apply(0, 0, 3'd3, 6'h3F, 1, 6'b001000, 1, 3'd3);
    hold_word = word(last_tag, 3);
    // Selected channel is not valid: the other valids are ignored.
    apply(0, 0, 3'd3, 6'b110111, 1, 6'b001000, 0, 0);
    // Drain: valid drops and data/src keep the last word.
    apply(0, 1, 0, 6'h00, 1, 6'h00, 0, 0);
    check_idle(hold_word, 3'd3);

    // Round-robin fairness: rr_ptr=5, all valid gives 0,1,2,3,4,5,0.
    for (int k = 0; k < 7; k++) begin
      apply(0, 1, 0, 6'h3F, 1, 6'(1 << (k % N)), 1, 3'(k % N));
    end
    apply(0, 1, 0, 6'h3F, 1, 6'b000010, 1, 3'd1);
    apply(0, 1, 0, 6'h3F, 1, 6'b000100, 1, 3'd2);

    // Backpressure: channel 2's word is held for 5 cycles, then channel 3
    // is granted in the release cycle.
    repeat (5) apply(0, 1, 0, 6'h3F, 0, 6'h00, 0, 0);
    apply(0, 1, 0, 6'h3F, 1, 6'b001000, 1, 3'd3);
    apply(0, 1, 0, 6'h00, 1, 6'h00, 0, 0);

    // Sparse and wrap: reset sets rr_ptr=5, only channels 5 and 1 valid.
    apply(1, 1, 0, 6'b100010, 1, 6'h00, 0, 0);
    apply(1, 1, 0, 6'b100010, 1, 6'h00, 0, 0);
    apply(0, 1, 0, 6'b100010, 1, 6'b000010, 1, 3'd1);
    apply(0, 1, 0, 6'b100010, 1, 6'b100000, 1, 3'd5);
    apply(0, 1, 0, 6'b100010, 1, 6'b000010, 1, 3'd1);
    apply(0, 1, 0, 6'b100010, 1, 6'b100000, 1, 3'd5);
    // Mid-stream reset discards the held word. The first grant afterwards
    // is channel 1.
    apply(1, 1, 0, 6'b100010, 0, 6'h00, 0, 0);
    apply(0, 1, 0, 6'b100010, 1, 6'b000010, 1, 3'd1);
    check("valid_after_rst", W'(out_valid), W'(1'b0));
    apply(0, 1, 0, 6'h00, 1, 6'h00, 0, 0);

`ifdef MUX_ARB_LOCK_EN
    // Lock: rr_ptr=1. Channel 2 sends 4 words locked 1,1,1,0 while
    // channels 0 and 4 are also valid. The order is 2,2,2,2, then 4, then 0.
    lock_pend = 6'b000100;
    repeat (3) apply(0, 1, 0, 6'b010101, 1, 6'b000100, 1, 3'd2);
    lock_pend = 6'b000000;
    apply(0, 1, 0, 6'b010101, 1, 6'b000100, 1, 3'd2);
    apply(0, 1, 0, 6'b010001, 1, 6'b010000, 1, 3'd4);
    apply(0, 1, 0, 6'b000001, 1, 6'b000001, 1, 3'd0);
    apply(0, 1, 0, 6'h00, 1, 6'h00, 0, 0);
`endif

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge CLK);
    check("sb_empty", W'(sb_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
